lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_gen.sv | 132 +++++++++++++
 tb/tb_lcd_timing_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: derives a clk/2 pixel clock, walks the (h,v) raster
// and produces the pixel coordinate decode plus registered panel sync/enable strobes.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 210,
  parameter int unsigned H_SYNC   = 1,
  parameter int unsigned H_BACK   = 45,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 22,
  parameter int unsigned V_SYNC   = 1,
  parameter int unsigned V_BACK   = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       disp_clk,
  output logic       disp_en,
  output logic       disp_hsync,
  output logic       disp_vsync
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_LO   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_ACT_LO   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_HI   = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);

  logic        phase_q, phase_d;
  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        disp_en_q, disp_en_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  logic        advance;
  logic        h_active;
  logic        v_active;
  logic        visible;
  logic        hsync_n;
  logic        vsync_n;

  // Raster decode of the current (h,v); drives the combinational pixel outputs
  // and is what the panel strobes capture one pixel period later.
  always_comb begin
    h_active = (h_q >= H_ACT_LO) && (h_q < H_ACT_HI);
    v_active = (v_q >= V_ACT_LO) && (v_q < V_ACT_HI);
    visible  = h_active && v_active;
    hsync_n  = !(h_q < H_SYNC_END);
    vsync_n  = !(v_q < V_SYNC_END);
    advance  = en && phase_q;
  end

  always_comb begin
    phase_d       = phase_q;
    h_d           = h_q;
    v_d           = v_q;
    disp_en_d     = disp_en_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (!en) begin
      phase_d   = 1'b0;
      h_d       = '0;
      v_d       = '0;
      disp_en_d = 1'b0;
      hsync_d   = 1'b1;
      vsync_d   = 1'b1;
    end else begin
      phase_d = ~phase_q;
      if (advance) begin
        disp_en_d = visible;
        hsync_d   = hsync_n;
        vsync_d   = vsync_n;
        // >= rather than == keeps the counters inside their range even from a corrupted state
        if (h_q >= H_LAST) begin
          h_d = '0;
          if (v_q >= V_LAST) begin
            v_d           = '0;
            frame_start_d = 1'b1;
          end else begin
            v_d = v_q + 11'd1;
          end
        end else begin
          h_d = h_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      disp_en_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      h_q           <= h_d;
      v_q           <= v_d;
      disp_en_q     <= disp_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    pixel_valid = visible;
    pixel_x     = visible ? 10'(h_q - H_ACT_LO) : '0;
    pixel_y     = visible ? 10'(v_q - V_ACT_LO) : '0;
    frame_start = frame_start_q;
    disp_clk    = phase_q;
    disp_en     = disp_en_q;
    disp_hsync  = hsync_q;
    disp_vsync  = vsync_q;
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a reduced-geometry instance under random reset/enable
// traffic and a default-geometry instance run far enough to reach the first visible line.
module tb_lcd_timing_gen;

  localparam int unsigned A_HS = 2, A_HB = 3, A_HA = 8, A_HF = 4;
  localparam int unsigned A_VS = 2, A_VB = 2, A_VA = 5, A_VF = 3;
  localparam int unsigned A_FRAME_CLK = 2 * (A_HS + A_HB + A_HA + A_HF) * (A_VS + A_VB + A_VA + A_VF);

  localparam int unsigned B_HS = 1, B_HB = 45, B_HA = 800, B_HF = 210;
  localparam int unsigned B_VS = 1, B_VB = 22, B_VA = 480, B_VF = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [9:0] px_a, py_a, px_b, py_b;
  logic       valid_a, fs_a, dclk_a, den_a, hs_a, vs_a;
  logic       valid_b, fs_b, dclk_b, den_b, hs_b, vs_b;

  lcd_timing_gen #(
    .H_ACTIVE(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_ACTIVE(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB)
  ) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a),
    .pixel_x(px_a), .pixel_y(py_a), .pixel_valid(valid_a), .frame_start(fs_a),
    .disp_clk(dclk_a), .disp_en(den_a), .disp_hsync(hs_a), .disp_vsync(vs_a)
  );

  lcd_timing_gen dut_b (
    .clk(clk), .reset(rst_b), .en(en_b),
    .pixel_x(px_b), .pixel_y(py_b), .pixel_valid(valid_b), .frame_start(fs_b),
    .disp_clk(dclk_b), .disp_en(den_b), .disp_hsync(hs_b), .disp_vsync(vs_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", tag, $time, got, got, exp, exp);
    end
  endtask

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [5:0] ctl;  // {pixel_valid, frame_start, disp_clk, disp_en, disp_hsync, disp_vsync}
  } exp_t;

  // Reference: everything follows from k = clk edges run since the last reset/disable.
  // Pixel period n = k/2 sits at raster position n mod frame; the strobes show position n-1.
  function automatic exp_t model(input longint k,
                                 input longint hs, input longint hb, input longint ha, input longint hf,
                                 input longint vs, input longint vb, input longint va, input longint vf);
    exp_t   e;
    longint ht, vt, n, pos, h, v, prev, hp, vp;
    logic   vis, ph, fs, den, hsy, vsy;
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    n   = k / 2;
    ph  = (k % 2) == 1;
    pos = n % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    vis = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    fs  = (k > 0) && !ph && (pos == 0);
    if (n == 0) begin
      den = 1'b0; hsy = 1'b1; vsy = 1'b1;
    end else begin
      prev = (n - 1) % (ht * vt);
      hp   = prev % ht;
      vp   = prev / ht;
      den  = (hp >= hs + hb) && (hp < hs + hb + ha) && (vp >= vs + vb) && (vp < vs + vb + va);
      hsy  = !(hp < hs);
      vsy  = !(vp < vs);
    end
    e.px  = vis ? 10'(h - hs - hb) : 10'd0;
    e.py  = vis ? 10'(v - vs - vb) : 10'd0;
    e.ctl = {vis, fs, ph, den, hsy, vsy};
    return e;
  endfunction

  longint ka = 0, kb = 0;
  always @(posedge clk) begin
    ka <= (rst_a || !en_a) ? 64'sd0 : ka + 1;
    kb <= (rst_b || !en_b) ? 64'sd0 : kb + 1;
  end

  logic checking = 1'b0;
  initial begin
    @(posedge clk);
    #1 checking = 1'b1;
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    if (checking) begin
      ea = model(ka, A_HS, A_HB, A_HA, A_HF, A_VS, A_VB, A_VA, A_VF);
      eb = model(kb, B_HS, B_HB, B_HA, B_HF, B_VS, B_VB, B_VA, B_VF);
      chk("a_pixel_x", 32'(px_a), 32'(ea.px));
      chk("a_pixel_y", 32'(py_a), 32'(ea.py));
      chk("a_ctl", 32'({valid_a, fs_a, dclk_a, den_a, hs_a, vs_a}), 32'(ea.ctl));
      chk("b_pixel_x", 32'(px_b), 32'(eb.px));
      chk("b_pixel_y", 32'(py_b), 32'(eb.py));
      chk("b_ctl", 32'({valid_b, fs_b, dclk_b, den_b, hs_b, vs_b}), 32'(eb.ctl));
    end
  end

  // Interval/width measurements taken only over uninterrupted runs.
  logic a_clean = 1'b0, b_clean = 1'b0;
  int   cyc = 0;
  int   a_last_fs = -1;
  int   b_last_hfall = -1, b_hlow = 0, b_vlow = 0, b_vrun = 0, b_vrise = -1;
  logic p_hs_b = 1'b1, p_vs_b = 1'b1, p_valid_b = 1'b0, p_den_b = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!a_clean) begin
      a_last_fs = -1;
    end else if (fs_a) begin
      if (a_last_fs >= 0) chk("a_frame_period", 32'(cyc - a_last_fs), 32'(A_FRAME_CLK));
      a_last_fs = cyc;
    end
    if (!b_clean) begin
      b_last_hfall = -1; b_hlow = 0; b_vlow = 0; b_vrun = 0; b_vrise = -1;
    end else begin
      if (p_hs_b && !hs_b) begin
        if (b_last_hfall >= 0) chk("b_hsync_period", 32'(cyc - b_last_hfall), 32'd2112);
        b_last_hfall = cyc;
      end
      if (!p_hs_b && hs_b) chk("b_hsync_width", 32'(b_hlow), 32'd2);
      if (!p_vs_b && vs_b) chk("b_vsync_width", 32'(b_vlow), 32'd2112);
      if (!p_valid_b && valid_b) b_vrise = cyc;
      if (p_valid_b && !valid_b) chk("b_valid_run", 32'(b_vrun), 32'd1600);
      if (!p_den_b && den_b && b_vrise >= 0) chk("b_den_lag", 32'(cyc - b_vrise), 32'd2);
      b_hlow = hs_b ? 0 : b_hlow + 1;
      b_vlow = vs_b ? 0 : b_vlow + 1;
      b_vrun = valid_b ? b_vrun + 1 : 0;
    end
    p_hs_b    = hs_b;
    p_vs_b    = vs_b;
    p_valid_b = valid_b;
    p_den_b   = den_b;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    fork
      begin : thread_a
        wait_clk(3);
        rst_a = 1'b0;
        wait_clk(4);
        en_a = 1'b1; a_clean = 1'b1;
        wait_clk(2 * A_FRAME_CLK + 20);
        a_clean = 1'b0;
        wait_clk(97);
        rst_a = 1'b1;
        wait_clk(1);
        rst_a = 1'b0;
        wait_clk(63);
        en_a = 1'b0;
        wait_clk(5);
        en_a = 1'b1;
        wait_clk(40);
        rst_a = 1'b1;
        wait_clk(4);
        rst_a = 1'b0;
        for (int unsigned i = 0; i < 3000; i++) begin
          int unsigned r;
          r = $urandom_range(0, 299);
          if (r == 0) begin
            rst_a = 1'b1;
            en_a  = 1'($urandom_range(0, 1));
            wait_clk($urandom_range(1, 3));
            rst_a = 1'b0;
            en_a  = 1'b1;
          end else if (r < 3) begin
            en_a = 1'b0;
            wait_clk($urandom_range(1, 6));
            en_a = 1'b1;
          end else begin
            wait_clk(1);
          end
        end
        wait_clk(A_FRAME_CLK + 10);
      end
      begin : thread_b
        wait_clk(4);
        rst_b = 1'b0; en_b = 1'b1; b_clean = 1'b1;
        wait_clk(51000);
        b_clean = 1'b0;
        wait_clk(37);
        rst_b = 1'b1;
        wait_clk(1);
        rst_b = 1'b0;
        wait_clk(301);
        en_b = 1'b0;
        wait_clk(6);
        en_b = 1'b1;
        wait_clk(50);
        rst_b = 1'b1;
        wait_clk(3);
        rst_b = 1'b0;
        wait_clk(2200);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
